// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states,
// well-known code addresses and the {pc, data} prefetch entry.
package fetch_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] BOOT_PC   = 32'h0000_0000;
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH x 64-bit entries with the head read from registers.
// Ports: clk, reset, push_i, pop_i, flush_i, din_i -> full_o, empty_o, head_o.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t din_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

    // A push into a full FIFO is legal when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: drives the ROM address, buffers {pc, word} pairs and
// hands them to decode over valid/ready; redirects flush, bad fetches halt.
// Ports: clk, reset, rom_addr/rom_data/rom_accessable (ROM side),
// redirect_valid/redirect_pc, inst_valid/inst_ready/inst_data/inst_pc,
// fault/fault_pc.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = BOOT_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        rom_accessable,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic [31:0] fault_pc
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_inc;
    logic         fault_q;
    logic [31:0]  fault_pc_q;

    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t fifo_din;
    logic         pop;
    logic         can_fetch;
    logic         push;

    assign inst_valid = !fifo_empty;
    assign inst_pc    = inst_valid ? fifo_head.pc   : 32'h0;
    assign inst_data  = inst_valid ? fifo_head.data : 32'h0;
    assign rom_addr   = pc_q;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

    assign pc_inc    = pc_q + 32'd4;
    assign pop       = inst_valid && inst_ready;
    assign can_fetch = (state_q == FETCH) && (!fifo_full || pop);
    // A redirect flushes, so anything fetched alongside it is dropped.
    assign push      = can_fetch && rom_accessable && !redirect_valid;

    assign fifo_din.pc   = pc_q;
    assign fifo_din.data = rom_data;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   (fifo_din),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else if (redirect_valid) begin
            state_q <= FETCH;
            pc_q    <= redirect_pc;
            fault_q <= 1'b0;
        end else if (can_fetch) begin
            if (rom_accessable) begin
                pc_q <= pc_inc;
            end else begin
                state_q    <= HALT;
                fault_q    <= 1'b1;
                fault_pc_q <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: ROM model, stream reference model,
// scoreboard monitor plus directed and randomized redirect/reset traffic.
module tb_inst_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_accessable;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    logic        exp_fault_valid = 1'b0;
    logic [31:0] exp_fault_pc = 32'h0;

    inst_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_accessable (rom_accessable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    always #5 clk = ~clk;

    // Mapped: boot stub 0..8, a 1 KiB text window, and the top 16 bytes.
    function automatic logic rom_acc(input logic [31:0] a);
        logic ok;
        ok = (a <= 32'h8)
          || (a >= 32'h0040_0000 && a < 32'h0040_0400)
          || (a >= 32'hFFFF_FFF0);
        return ok && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h3c11_0040;
            32'h4:   return 32'h2631_0000;
            32'h8:   return 32'h0220_0008;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    always_comb begin
        rom_data       = rom_word(rom_addr);
        rom_accessable = rom_acc(rom_addr);
    end

    // Expected delivery after a restart at pc: consecutive words until
    // the first unmapped address, which is where the fault must land.
    task automatic build(input logic [31:0] start);
        logic [31:0] p;
        exp_t        e;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 300; i++) begin
            if (!rom_acc(p)) break;
            e.pc   = p;
            e.data = rom_word(p);
            exp_q.push_back(e);
            p = p + 32'd4;
        end
        exp_fault_valid = !rom_acc(p);
        exp_fault_pc    = p;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: cycles carrying reset or redirect are not
    // counted, since those transfers are discarded.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !redirect_valid) begin
            if (inst_valid && inst_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_pop: got pc %h expected none",
                             inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_inst_pc", inst_pc, e.pc);
                    chk("sb_inst_data", inst_data, e.data);
                end
            end else if (!inst_valid) begin
                chk("idle_inst_pc", inst_pc, 32'h0);
                chk("idle_inst_data", inst_data, 32'h0);
            end
            if (fault) begin
                chk1("sb_fault_expected", exp_fault_valid, 1'b1);
                chk("sb_fault_pc", fault_pc, exp_fault_pc);
                chk("sb_fault_rom_addr", rom_addr, exp_fault_pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        exp_q.delete();
        exp_fault_valid = 1'b0;
        tick();
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        reset = 1'b0;
        build(32'h0);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        build(pc);
        tick();
        redirect_valid = 1'b0;
        chk("redir_rom_addr", rom_addr, pc);
        chk1("redir_gap_valid", inst_valid, 1'b0);
        chk1("redir_fault_clr", fault, 1'b0);
        tick();
        chk1("redir_first_valid", inst_valid, rom_acc(pc));
        chk1("redir_fault", fault, !rom_acc(pc));
        if (rom_acc(pc)) chk("redir_first_pc", inst_pc, pc);
        else chk("redir_fault_pc", fault_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] tgt;
        // Boot stream at full throughput, then fault at 0xC.
        inst_ready = 1'b1;
        do_reset();
        tick();
        chk1("boot0_valid", inst_valid, 1'b1);
        chk("boot0_pc", inst_pc, 32'h0);
        chk("boot0_data", inst_data, 32'h3c11_0040);
        tick();
        chk("boot1_pc", inst_pc, 32'h4);
        tick();
        chk("boot2_pc", inst_pc, 32'h8);
        chk("boot2_data", inst_data, 32'h0220_0008);
        tick();
        chk1("boot_fault", fault, 1'b1);
        chk("boot_fault_pc", fault_pc, 32'hC);
        chk1("boot_drained", inst_valid, 1'b0);

        // Backpressure: FIFO fills and the fetch address holds at 8.
        inst_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i >= 2) chk("hold_rom_addr", rom_addr, 32'h8);
        end
        chk("hold_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        chk("rel_head_pc", inst_pc, 32'h4);
        tick();
        chk1("rel_fault", fault, 1'b1);
        chk("rel_fault_pc", fault_pc, 32'hC);
        chk("rel_buffered_pc", inst_pc, 32'h8);
        tick();
        chk1("rel_empty", inst_valid, 1'b0);
        chk("rel_no_fetch", rom_addr, 32'hC);

        // Redirect while full with a pop in the same cycle.
        inst_ready = 1'b0;
        do_redirect(32'h0040_0100);
        tick();
        chk("full_rom_addr", rom_addr, 32'h0040_0108);
        inst_ready = 1'b1;
        do_redirect(32'h0040_0000);
        repeat (4) tick();

        // Misaligned redirect faults without delivering anything.
        do_redirect(32'h0040_0002);
        tick();
        chk1("misal_valid", inst_valid, 1'b0);
        chk("misal_fault_pc", fault_pc, 32'h0040_0002);

        // Redirect coinciding with a would-be fault.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        build(32'hC);
        tick();
        chk("same_rom_addr", rom_addr, 32'hC);
        redirect_pc = 32'h0040_0000;
        build(32'h0040_0000);
        tick();
        redirect_valid = 1'b0;
        chk1("same_fault", fault, 1'b0);
        chk("same_rom_addr2", rom_addr, 32'h0040_0000);
        tick();
        chk("same_first_pc", inst_pc, 32'h0040_0000);
        repeat (3) tick();

        // Address wrap from the top of memory into the boot stub.
        do_redirect(32'hFFFF_FFF8);
        repeat (7) tick();
        chk1("wrap_fault", fault, 1'b1);
        chk("wrap_fault_pc", fault_pc, 32'hC);

        // Random redirects, resets and backpressure.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 4))
                    0: tgt = 32'h0040_0000 + (32'($urandom_range(0, 255)) << 2);
                    1: tgt = 32'h0040_03F0;
                    2: tgt = 32'h0040_0000 + 32'($urandom_range(1, 3));
                    3: tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
                    default: tgt = 32'h0000_0100;
                endcase
                do_redirect(tgt);
            end
            repeat ($urandom_range(3, 30)) begin
                inst_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end

        // Mid-stream reset returns everything to reset values.
        inst_ready = 1'b1;
        do_redirect(32'h0040_0040);
        tick();
        do_reset();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
